// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern IDs, select-code decode and the pattern-select FSM states.
// Consumed by pattern_select_ctrl (optional AUTO_CYCLE_EN feature uses next_pattern).
package vga_pkg;

    localparam int PATTERN_WIDTH = 3;

    localparam logic [2:0] PAT_0 = 3'b001;
    localparam logic [2:0] PAT_1 = 3'b010;
    localparam logic [2:0] PAT_2 = 3'b100;
    localparam logic [2:0] PAT_3 = 3'b101;

    // Shared with vga_sync_pulse
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_ROWS = 480;

    typedef enum logic {IDLE, PENDING} state_e;

    function automatic logic [2:0] decode_sel(input logic [1:0] code);
        case (code)
            2'b00:   decode_sel = PAT_0;
            2'b01:   decode_sel = PAT_1;
            2'b10:   decode_sel = PAT_2;
            default: decode_sel = PAT_3;
        endcase
    endfunction

    function automatic logic [2:0] next_pattern(input logic [2:0] pat);
        case (pat)
            PAT_0:   next_pattern = PAT_1;
            PAT_1:   next_pattern = PAT_2;
            PAT_2:   next_pattern = PAT_3;
            default: next_pattern = PAT_0;
        endcase
    endfunction

endpackage

// File: rtl/pattern_select_ctrl_sel_debounce.sv
// Two-flop synchroniser and hold-time debouncer for the 2-bit board select code.
// o_stable is the stable code as of the next edge, so it carries the accepted code during o_accept.
module sel_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_raw,
    output logic [1:0] o_stable,
    output logic       o_accept
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    s1_q, s2_q;
    logic [1:0]    stable_q, stable_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_comb begin
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d  = '0;
            cand_d = s2_q;
        end else if (cnt_q != '0 && s2_q != cand_q) begin
            // Candidate moved mid-count: restart timing on the new code
            cnt_d  = '0;
            cand_d = s2_q;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            accept   = 1'b1;
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d  = cnt_q + 1'b1;
            cand_d = s2_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= i_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stable = stable_d;
    assign o_accept = accept;

endmodule

// File: rtl/pattern_select_ctrl.sv
// Debounced pattern selection committed only at vsync falling edges (frame boundaries).
// Optional macro AUTO_CYCLE_EN adds i_auto: timed pattern rotation every AUTO_FRAMES boundaries.
module pattern_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PATTERN_WIDTH   = vga_pkg::PATTERN_WIDTH,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sel0,
    input  logic                     i_sel1,
    input  logic                     i_vsync,
`ifdef AUTO_CYCLE_EN
    input  logic                     i_auto,
`endif
    output logic [PATTERN_WIDTH-1:0] o_pattern,
    output logic                     o_pending
);

    import vga_pkg::*;

    localparam int PW = PATTERN_WIDTH;

    logic [1:0]    stable;
    logic          accept;
    logic          acc;
    logic          boundary;
    logic          vs_q;
    logic [PW-1:0] cand_pat;
    state_e        state_q;
    logic [PW-1:0] pattern_q, target_q;
    logic          pending_q;

    sel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_raw    ({i_sel0, i_sel1}),
        .o_stable (stable),
        .o_accept (accept)
    );

    assign boundary = vs_q & ~i_vsync;
    assign cand_pat = PW'(decode_sel(stable));

`ifdef AUTO_CYCLE_EN
    localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic          auto_q;
    logic [FW-1:0] fcnt_q;
    // Leaving auto mode replays the current stable code as a fresh accept
    assign acc = (accept | auto_q) & ~i_auto;
`else
    assign acc = accept;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vs_q      <= 1'b0;
            state_q   <= IDLE;
            pattern_q <= PW'(PAT_0);
            target_q  <= PW'(PAT_0);
            pending_q <= 1'b0;
`ifdef AUTO_CYCLE_EN
            auto_q    <= 1'b0;
            fcnt_q    <= '0;
`endif
        end else begin
            vs_q <= i_vsync;
`ifdef AUTO_CYCLE_EN
            auto_q <= i_auto;
            if (i_auto) begin
                state_q   <= IDLE;
                pending_q <= 1'b0;
                if (boundary) begin
                    if (fcnt_q == FW'(AUTO_FRAMES - 1)) begin
                        pattern_q <= PW'(next_pattern(3'(pattern_q)));
                        fcnt_q    <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
            end else begin
                fcnt_q <= '0;
`else
            begin
`endif
                case (state_q)
                    IDLE: begin
                        if (acc && cand_pat != pattern_q) begin
                            target_q  <= cand_pat;
                            state_q   <= PENDING;
                            pending_q <= 1'b1;
                        end
                    end
                    PENDING: begin
                        // A new accept wins over a same-cycle boundary; the old target is dropped
                        if (acc) begin
                            if (cand_pat == pattern_q) begin
                                state_q   <= IDLE;
                                pending_q <= 1'b0;
                            end else begin
                                target_q <= cand_pat;
                            end
                        end else if (boundary) begin
                            pattern_q <= target_q;
                            pending_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_pattern = pattern_q;
    assign o_pending = pending_q;

endmodule

// File: doc/pattern_select_ctrl.md
Name: pattern_select_ctrl

Overview:
Control stage directly upstream of test_pattern_gen. It synchronises and debounces the two board select pins and maps the settled code to a 3-bit pattern ID. It commits each pattern change only at a frame boundary, so a displayed frame never mixes two patterns. Its o_pattern output replaces the combinational sel0/sel1 decode in the VGA top and drives test_pattern_gen.i_pattern.

Parameters:
DEBOUNCE_CYCLES, 250000, number of consecutive pclk cycles a new select code must hold to be accepted (10 ms at 25 MHz); minimum 2.
PATTERN_WIDTH, 3, width of the pattern ID bus.
AUTO_FRAMES, 120, frame boundaries between automatic advances (used only with AUTO_CYCLE_EN).

Ports:
i_clk  in  1  pixel clock (25 MHz pclk from ip_pll).
i_rst  in  1  asynchronous, active-high reset.
i_sel0  in  1  raw board select pin, MSB of code, asynchronous.
i_sel1  in  1  raw board select pin, LSB of code, asynchronous.
i_vsync  in  1  vsync from vga_sync_pulse, synchronous to i_clk, high during active rows.
o_pattern  out  PATTERN_WIDTH  committed pattern ID to test_pattern_gen.
o_pending  out  1  high while a debounced change waits for a frame boundary.

Behaviour:
- Reset (async assert, sync release), all values in this state:
  - o_pattern = 3'b001; o_pending = 0.
  - Synchroniser flops = 0; stable code = 2'b00; debounce counter = 0; frame counter = 0; state = IDLE.
- Synchroniser: two flops per pin; sync_code = {sel0_s2, sel1_s2}. Two cycles of latency before debouncing starts.
- Decode map: 00->001, 01->010, 10->100, 11->101.
- Debounce:
  - When sync_code != stable code, the counter increments each cycle the candidate stays unchanged.
  - If the candidate changes, the counter reloads to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable code <= candidate and a one-cycle "accept" pulse is issued.
  - When sync_code == stable code, the counter holds at 0.
- Frame boundary: falling edge of i_vsync (prev=1, now=0), detected with one registered copy of i_vsync.
- FSM states:
  - IDLE: waiting for a change. On accept with decode(stable) != o_pattern -> PENDING, o_pending=1. On accept with decode(stable) == o_pattern -> stay in IDLE.
  - PENDING: a change is waiting. On frame boundary -> o_pattern <= decode(stable) on the next clock edge, o_pending=0, state -> IDLE.
  - PENDING, new accept: overwrites the pending target. If the new target equals o_pattern, the pending change is cancelled and the FSM returns to IDLE.
- Simultaneous accept and frame boundary in one cycle: the accept takes priority and its commit waits for the next boundary. The stale target is never committed.
- Latency, pin to o_pattern: 2 (sync) + DEBOUNCE_CYCLES + wait for boundary + 1 cycle.
- Counter widths: debounce counter is $clog2(DEBOUNCE_CYCLES) bits; frame counter is $clog2(AUTO_FRAMES) bits; both wrap to 0, never overflow.
- Reset mid-PENDING: the pending change is discarded and o_pattern returns to 001 immediately.

Optional Feature:
Macro: AUTO_CYCLE_EN.
- Defined:
  - Adds input port i_auto (1 bit, synchronous to i_clk).
  - While i_auto=1, the select pins are ignored for commits. The frame counter counts boundaries and on reaching AUTO_FRAMES-1 advances o_pattern at that boundary: 001->010->100->101->001. The counter then wraps to 0.
  - Any pending change is cleared on i_auto rising.
  - When i_auto falls, the debounced stable code is re-evaluated as an accept in the next cycle.
- Undefined: no i_auto port, no frame counter logic; behaviour is exactly as above.

Decomposition:
- Shared package vga_pkg:
  - PATTERN_WIDTH.
  - Pattern constants PAT_0=3'b001, PAT_1=3'b010, PAT_2=3'b100, PAT_3=3'b101.
  - The 2-bit-code-to-pattern decode function.
  - FSM state enum {IDLE, PENDING}.
  - Timing constants shared with vga_sync_pulse (TOTAL_ROWS=525, ACTIVE_ROWS=480).
- One sub-module, sel_debounce: synchroniser plus counter for a 2-bit bus; outputs the stable code and the accept pulse.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_FRAMES=2, vsync period shortened to 40 cycles with 10 low):
1. Release reset with sel=00 -> o_pattern=001 and o_pending=0 for 3 frames.
2. Set sel=10 mid-frame -> o_pending rises 6 cycles later; o_pattern stays 001 until the vsync falling edge, then becomes 100 one cycle after; o_pending drops at the same edge.
3. Set sel=01, toggling every 2 cycles for 20 cycles, then return to 00 -> no accept, o_pending never rises, o_pattern stays 001.
4. While PENDING to 010, set sel back to 00 and hold -> pending cancelled, o_pending=0, o_pattern stays 001 across the boundary.
5. Force the accept on the same cycle as a vsync falling edge (target 101) -> no change at that edge; o_pattern=101 after the following edge.
6. Assert i_rst while PENDING with o_pattern=100 -> o_pattern=001 and o_pending=0 asynchronously. With AUTO_CYCLE_EN and i_auto=1: 001->010 after 2 boundaries, ->100 after 4.
